// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave and the master-side bridge.
// Response codes, burst types and the one-hot slave FSM encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [5:0] {
        StIdle   = 6'b000001,
        StRdReq  = 6'b000010,
        StRdWait = 6'b000100,
        StRdResp = 6'b001000,
        StWrData = 6'b010000,
        StWrResp = 6'b100000
    } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for AXI bursts.
// FIXED holds the address; every other burst type steps by the transfer size.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    always_comb begin
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else begin
            // Plain 32-bit add, so the address wraps at the top of the space.
            next_addr_o = addr_i + (32'd1 << size_i);
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-ID AXI3 slave serving one transaction at a time from a one-cycle
// synchronous SRAM; INCR/FIXED bursts, IDs echoed on R and B.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned MEM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  count_q, count_d;
    logic        err_q, err_d;

    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        rvalid_q, rvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        bvalid_q, bvalid_d;

    logic [31:0] next_addr;
    logic        last_beat;
    logic        err_next;

    logic unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    axi_burst_addr u_burst_addr (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign last_beat = (count_q == len_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        count_d   = count_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        err_next  = err_q;

        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        ram_en    = 1'b0;
        ram_wen   = 4'b0000;
        ram_wdata = 32'd0;
        ram_addr  = addr_q[MEM_AW+1:2];

        unique case (state_q)
            StIdle: begin
                awready = 1'b1;
                // Write has priority: the read is held off while awvalid is up.
                arready = ~awvalid;
                if (awvalid) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    id_d    = awid;
                    count_d = 8'd0;
                    err_d   = 1'b0;
                    state_d = StWrData;
                end else if (arvalid) begin
                    addr_d  = araddr;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    id_d    = arid;
                    count_d = 8'd0;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                ram_en  = 1'b1;
                state_d = StRdWait;
            end
            StRdWait: begin
                rdata_d  = ram_rdata;
                rid_d    = id_q;
                rresp_d  = RESP_OKAY;
                rlast_d  = last_beat;
                rvalid_d = 1'b1;
                state_d  = StRdResp;
            end
            StRdResp: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = StRdReq;
                    end
                end
            end
            StWrData: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_en    = 1'b1;
                    ram_wen   = wstrb;
                    ram_wdata = wdata;
                    // A misplaced wlast still writes the beat but poisons the response.
                    err_next  = err_q | (wlast != last_beat);
                    err_d     = err_next;
                    if (last_beat) begin
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = err_next ? RESP_SLVERR : RESP_OKAY;
                        state_d  = StWrResp;
                    end else begin
                        count_d = count_q + 8'd1;
                        addr_d  = next_addr;
                    end
                end
            end
            StWrResp: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= BURST_FIXED;
            id_q     <= 4'd0;
            count_q  <= 8'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rid_q    <= 4'd0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
            bid_q    <= 4'd0;
            bresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            id_q     <= id_d;
            count_q  <= count_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rid    = rid_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rvalid = rvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural one-cycle SRAM.
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_axi_sram_slave;

    localparam int unsigned MEM_AW = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [3:0]  arid = '0;    logic [31:0] araddr = '0;  logic [7:0] arlen = '0;
    logic [2:0]  arsize = '0;  logic [1:0]  arburst = '0; logic arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;          logic [31:0] rdata;        logic [1:0] rresp;
    logic        rlast, rvalid; logic rready = 1'b0;
    logic [3:0]  awid = '0;    logic [31:0] awaddr = '0;  logic [7:0] awlen = '0;
    logic [2:0]  awsize = '0;  logic [1:0]  awburst = '0; logic awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;   logic [3:0]  wstrb = '0;   logic wlast = 1'b0;
    logic        wvalid = 1'b0; logic wready;
    logic [3:0]  bid;          logic [1:0]  bresp;        logic bvalid;
    logic        bready = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic              ld_en = 1'b0;
    logic [MEM_AW-1:0] ld_addr = '0;
    logic [31:0]       ld_data = '0;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (ram_en) begin
            if (ram_wen == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'b0000), .arprot(3'b000),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'b0000), .awprot(3'b000),
        .awvalid(awvalid), .awready(awready),
        .wid(4'd0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Single-beat INCR read with latency checks; ends back in IDLE.
    task automatic single_read(input string tag, input logic [31:0] a, input logic [3:0] id,
                               input logic [31:0] exp);
        araddr = a; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = id; arvalid = 1'b1;
        #1;
        check({tag, ".arready"}, arready, 1'b1);
        tick();
        arvalid = 1'b0;
        check({tag, ".ram_en"}, ram_en, 1'b1);
        check({tag, ".ram_addr"}, ram_addr, a[MEM_AW+1:2]);
        tick();
        check({tag, ".rvalid_early"}, rvalid, 1'b0);
        tick();
        check({tag, ".rvalid"}, rvalid, 1'b1);
        check({tag, ".rdata"}, rdata, exp);
        check({tag, ".rid"}, rid, id);
        check({tag, ".rlast"}, rlast, 1'b1);
        check({tag, ".rresp"}, rresp, 2'b00);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, ".rvalid_drop"}, rvalid, 1'b0);
    endtask

    // One W beat; the comb SRAM strobe is checked in the handshake cycle.
    task automatic w_beat(input string tag, input logic [31:0] d, input logic [3:0] s,
                          input logic l, input logic [MEM_AW-1:0] exp_addr);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        #1;
        check({tag, ".wready"}, wready, 1'b1);
        check({tag, ".ram_wen"}, ram_wen, s);
        check({tag, ".ram_addr"}, ram_addr, exp_addr);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic aw_req(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [3:0] id);
        awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
    endtask

    task automatic b_accept(input string tag, input logic [3:0] id, input logic [1:0] resp);
        check({tag, ".bvalid"}, bvalid, 1'b1);
        check({tag, ".bid"}, bid, id);
        check({tag, ".bresp"}, bresp, resp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, ".bvalid_drop"}, bvalid, 1'b0);
    endtask

    initial begin
        // Reset state and SRAM preload (the model ignores reset).
        load(14'h10, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) load(14'h40 + 14'(i), 32'h1111_0000 + 32'(i));
        check("rst.rvalid", rvalid, 1'b0);
        check("rst.bvalid", bvalid, 1'b0);
        check("rst.rlast", rlast, 1'b0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.ids", {rid, bid}, 8'd0);
        check("rst.resps", {rresp, bresp}, 4'd0);
        reset = 1'b0;
        tick();
        check("idle.awready", awready, 1'b1);
        check("idle.wready", wready, 1'b0);
        check("idle.ram_en", ram_en, 1'b0);

        single_read("rd1", 32'h40, 4'd3, 32'hDEADBEEF);

        // Byte write into lane 1 of word 0x10.
        aw_req(32'h41, 8'd0, 3'd0, 2'b01, 4'd5);
        w_beat("bw", 32'h0000AB00, 4'b0010, 1'b1, 14'h10);
        b_accept("bw", 4'd5, 2'b00);
        single_read("bw_rb", 32'h40, 4'd4, 32'hDEADABEF);

        // INCR burst of four with a five-cycle stall on beat 1.
        araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 4'd7;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("burst.ram_addr", ram_addr, 14'h40 + 14'(b));
            tick();
            tick();
            check("burst.rvalid", rvalid, 1'b1);
            check("burst.rdata", rdata, 32'h1111_0000 + 32'(b));
            check("burst.rlast", rlast, (b == 3));
            check("burst.rid", rid, 4'd7);
            if (b == 0) begin
                held = rdata;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall.rvalid", rvalid, 1'b1);
                    check("stall.rdata", rdata, held);
                    check("stall.rlast", rlast, 1'b0);
                end
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check("burst.end_rvalid", rvalid, 1'b0);
        check("burst.end_arready", arready, 1'b1);

        // Simultaneous AR/AW: write to word 0x12 first, then read it back.
        awaddr = 32'h48; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awid = 4'd1;
        araddr = 32'h48; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 4'd2;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("sim.arready_blocked", arready, 1'b0);
        check("sim.awready", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        check("sim.arready_wr", arready, 1'b0);
        w_beat("sim.w", 32'hCAFEF00D, 4'b1111, 1'b1, 14'h12);
        check("sim.arready_b", arready, 1'b0);
        b_accept("sim.b", 4'd1, 2'b00);
        check("sim.arready_idle", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        tick();
        tick();
        check("sim.rvalid", rvalid, 1'b1);
        check("sim.rdata", rdata, 32'hCAFEF00D);
        check("sim.rid", rid, 4'd2);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // Early wlast on a two-beat burst: both beats land, SLVERR returned.
        aw_req(32'h80, 8'd1, 3'd2, 2'b01, 4'd6);
        w_beat("wl.b0", 32'h11, 4'b1111, 1'b1, 14'h20);
        check("wl.bvalid_mid", bvalid, 1'b0);
        w_beat("wl.b1", 32'h22, 4'b1111, 1'b1, 14'h21);
        b_accept("wl", 4'd6, 2'b10);
        single_read("wl_rb0", 32'h80, 4'd8, 32'h11);
        single_read("wl_rb1", 32'h84, 4'd8, 32'h22);

        // FIXED burst of three hits the same word each beat.
        aw_req(32'h90, 8'd2, 3'd2, 2'b00, 4'd10);
        w_beat("fx.b0", 32'hA, 4'b1111, 1'b0, 14'h24);
        w_beat("fx.b1", 32'hB, 4'b1111, 1'b0, 14'h24);
        w_beat("fx.b2", 32'hC, 4'b1111, 1'b1, 14'h24);
        b_accept("fx", 4'd10, 2'b00);
        single_read("fx_rb", 32'h90, 4'd11, 32'hC);

        // Asynchronous reset while beat 2 of a burst is waiting for rready.
        araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 4'd9;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        tick();
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        tick();
        check("rstmid.beat2", rvalid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.rvalid_async", rvalid, 1'b0);
        check("rstmid.rdata_async", rdata, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rstmid.arready", arready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstmid.no_stale", rvalid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
